xor_parity_seq: RTL and testbench
=================================

# xor_parity_seq

Multi-cycle parity sequencer that computes the XOR reduction of a WIDTH-bit word by feeding it, one nibble per clock, through a single shared `xor4` gate instance. It accepts a word with a ready/start handshake, accumulates the nibble parities in a state machine, and holds the result with a valid/ack handshake. It sits between a data source and a parity consumer wherever a full-width XOR tree is too large.

## Interface

Parameters:
- `WIDTH`, default 16: input word width. Must be a multiple of 4 and at least 4. `NIB = WIDTH/4` is the number of nibbles.

Ports:
- `clk`, input, 1 bit: single clock, rising-edge.
- `rstn`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: request to begin. Sampled only while `ready`=1.
- `data`, input, WIDTH bits: word to reduce. Captured on the edge that accepts `start`.
- `ack`, input, 1 bit: consumer acknowledges the result. Sampled only while `valid`=1.
- `ready`, output, 1 bit: block is idle and will accept `start`.
- `busy`, output, 1 bit: reduction in progress.
- `valid`, output, 1 bit: `parity` holds a completed result.
- `parity`, output, 1 bit: parity result.

## Operation

- One `xor4` instance. Its inputs are `sh[3:0]` and its output is `z`.
- Registers:
  - `sh`, WIDTH bits: shift register.
  - `acc`, 1 bit: parity accumulator.
  - `cnt`, $clog2(NIB)+1 bits: nibble counter.
  - `state`: IDLE, RUN or HOLD.
- IDLE:
  - `ready`=1.
  - When `start`=1: load `sh`<=`data`, `acc`<=0, `cnt`<=0, then go to RUN.
- RUN:
  - `busy`=1.
  - Each clock: `acc`<=`acc`^`z`, `sh`<=`sh`>>4 (zero fill), `cnt`<=`cnt`+1.
  - When `cnt`==NIB-1, that same edge performs the final accumulate and goes to HOLD.
- HOLD:
  - `valid`=1 and `parity` is stable.
  - When `ack`=1, go to IDLE.
- `ready`, `busy` and `valid` are one-hot decodes of `state`. Exactly one is high at any time after reset.
- `start` while in RUN or HOLD is ignored. It is not queued.
- `ack` outside HOLD is ignored.
- `ack` and `start` high together in HOLD: the `ack` is taken and the `start` is ignored. A new word is accepted no earlier than the edge after `ready` rises.
- `data` changes after the accepting edge have no effect on the result.
- `parity` is driven from `acc` (see Configuration). In IDLE and RUN it is 0, because `acc` is not exposed until HOLD.

## Timing

- Reset value of every output: `ready`=1, `busy`=0, `valid`=0, `parity`=0. Internal registers reset to 0 and `state` resets to IDLE.
- Reset mid-operation: asserting `rstn`=0 in any state returns the block to IDLE immediately and asynchronously. Any partial result is discarded. `valid` never glitches high during the reset.
- Latency: if `start` is accepted at edge E0, `valid` rises after edge E_NIB, i.e. NIB clocks later. For the default WIDTH=16 this is 4 clocks.
- `valid` stays high for at least one cycle and until `ack`. `ready` rises on the edge that samples `ack`.
- Throughput: one word per NIB+2 cycles when `ack` is tied high.
  - NIB cycles in RUN.
  - One cycle in HOLD.
  - One cycle in IDLE.
- All outputs are registered or are decodes of `state` only. There is no combinational path from `start`, `ack` or `data` to any output.
- WIDTH=4 boundary: RUN lasts exactly one cycle.

## Configuration

- Macro `XOR_PARITY_SEQ_ODD_EN`.
  - Defined: `parity` = ~`acc` in HOLD. This is odd parity: the output is 1 when the word contains an even number of ones.
  - Not defined: `parity` = `acc` in HOLD. This is even parity, the plain XOR reduction.
- In both builds `parity` is 0 outside HOLD.

## Test plan

- Reset, then `start` with `data`=16'h0001 and `ack` held low:
  - `busy` is high for 4 cycles.
  - `valid`=1 with `parity`=1, and `valid` holds until `ack`.
- `data`=16'hFFFF gives `parity`=0. `data`=16'h8421 gives `parity`=0. `data`=16'h7000 gives `parity`=1. All in the default build.
- `start` pulsed with `data`=16'h0003 while RUN and again while HOLD:
  - Both pulses are ignored.
  - The result is that of the original word, and no second result appears.
- `ack` tied to 1 with back-to-back `start` pulses:
  - One result every 6 cycles.
  - `ready`, `busy` and `valid` are one-hot on every cycle.
- Assert `rstn`=0 during the 2nd RUN cycle:
  - All outputs return to their reset values immediately.
  - A subsequent `start` with 16'h0001 completes normally with `parity`=1.
- Build with `XOR_PARITY_SEQ_ODD_EN`:
  - 16'h0001 gives `parity`=0.
  - 16'h0000 gives `parity`=1.
  - Repeat with WIDTH=4 and `data`=4'hB: 1-cycle RUN, and `parity`=0 in the odd build, `parity`=1 in the default build.

Source files
------------

// File: rtl/xor_parity_seq.sv
// Multi-cycle parity sequencer: reduces a WIDTH-bit word one nibble per clock through a single xor4.
// Optional build macro XOR_PARITY_SEQ_ODD_EN selects odd parity (inverted result in HOLD).

module xor4 (
    input  logic [3:0] a_i,
    output logic       z_o
);
    assign z_o = ^a_i;
endmodule

module xor_parity_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic             parity
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(NIB) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               parity_q, parity_d;
    logic               z;

    xor4 u_xor4 (
        .a_i (sh_q[3:0]),
        .z_o (z)
    );

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sh_q     <= {WIDTH{1'b0}};
            acc_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
        end
    end

    // Next-state and datapath update; parity register is loaded only on entry to HOLD.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        case (state_q)
            IDLE: begin
                parity_d = 1'b0;
                if (start) begin
                    sh_d    = data;
                    acc_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_q ^ z;
                sh_d  = sh_q >> 3'd4;
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_W'(NIB - 1)) begin
`ifdef XOR_PARITY_SEQ_ODD_EN
                    parity_d = ~(acc_q ^ z);
`else
                    parity_d = acc_q ^ z;
`endif
                    state_d = HOLD;
                end else begin
                    parity_d = 1'b0;
                    state_d  = RUN;
                end
            end
            HOLD: begin
                // ack wins over a simultaneous start; the new word waits for IDLE.
                if (ack) begin
                    parity_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                parity_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign ready  = (state_q == IDLE);
    assign busy   = (state_q == RUN);
    assign valid  = (state_q == HOLD);
    assign parity = parity_q;

endmodule

// File: tb/tb_xor_parity_seq.sv
// Directed scoreboard bench for xor_parity_seq (WIDTH=16 and WIDTH=4 instances).

module tb_xor_parity_seq;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start, ack;
    logic [15:0] data;
    logic        ready, busy, valid, parity;
    logic        start4, ack4;
    logic [3:0]  data4;
    logic        ready4, busy4, valid4, parity4;

    int vectors = 0;
    int miscompares = 0;
    logic sb[$];

    xor_parity_seq #(.WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .data(data), .ack(ack),
        .ready(ready), .busy(busy), .valid(valid), .parity(parity)
    );

    xor_parity_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .data(data4), .ack(ack4),
        .ready(ready4), .busy(busy4), .valid(valid4), .parity(parity4)
    );

    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [15:0] d);
`ifdef XOR_PARITY_SEQ_ODD_EN
        return ~(^d);
`else
        return ^d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        logic e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(tag, {31'd0, parity}, {31'd0, e});
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, {31'd0, valid}, 32'd1);
    endtask

    // One word with ack held low: counts RUN cycles, then holds before acking.
    task automatic run_word(input string tag, input logic [15:0] d);
        int n;
        start = 1'b1;
        data  = d;
        sb.push_back(exp_par(d));
        tick();
        start = 1'b0;
        data  = ~d;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        check({tag, "_run_cycles"}, 32'(n), 32'd4);
        check({tag, "_valid"}, {31'd0, valid}, 32'd1);
        pop_check({tag, "_parity"});
        tick();
        tick();
        check({tag, "_valid_hold"}, {31'd0, valid}, 32'd1);
        check({tag, "_parity_hold"}, {31'd0, parity}, {31'd0, exp_par(d)});
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ready_after_ack"}, {29'd0, ready, busy, valid}, 32'b100);
        check({tag, "_parity_idle"}, {31'd0, parity}, 32'd0);
    endtask

    initial begin
        int last;
        logic e;
        rstn = 1'b0; start = 1'b0; ack = 1'b0; data = 16'h0000;
        start4 = 1'b0; ack4 = 1'b0; data4 = 4'h0;
        #2;
        check("reset_outs", {28'd0, ready, busy, valid, parity}, 32'b1000);
        check("reset_outs4", {28'd0, ready4, busy4, valid4, parity4}, 32'b1000);
        #10 rstn = 1'b1;
        tick();
        check("idle_after_reset", {28'd0, ready, busy, valid, parity}, 32'b1000);

        run_word("w0001", 16'h0001);
        run_word("wFFFF", 16'hFFFF);
        run_word("w8421", 16'h8421);
        run_word("w7000", 16'h7000);
        run_word("w0000", 16'h0000);

        // start pulses during RUN and HOLD are ignored
        start = 1'b1; data = 16'h0001; sb.push_back(exp_par(16'h0001));
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; data = 16'h0003;
        tick();
        start = 1'b0; data = 16'hA5A5;
        wait_valid("ign");
        pop_check("ign_parity");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_hold_stays", {29'd0, ready, busy, valid}, 32'b001);
        start = 1'b1; ack = 1'b1;
        tick();
        start = 1'b0; ack = 1'b0;
        check("ack_beats_start", {29'd0, ready, busy, valid}, 32'b100);
        tick();
        tick();
        check("no_second_result", {29'd0, ready, busy, valid}, 32'b100);

        // back-to-back with ack tied high
        last = -1;
        ack = 1'b1; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            check("onehot", 32'($countones({ready, busy, valid})), 32'd1);
            if (valid === 1'b1) begin
                if (last >= 0) check("b2b_spacing", 32'(c - last), 32'd6);
                last = c;
                pop_check("b2b_parity");
            end
            data = 16'($urandom);
            if (ready === 1'b1) sb.push_back(exp_par(data));
            tick();
        end
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (valid === 1'b1) pop_check("b2b_drain");
            tick();
        end
        ack = 1'b0;
        check("b2b_sb_empty", 32'(sb.size()), 32'd0);
        check("b2b_seen", {31'd0, last >= 0}, 32'd1);

        // asynchronous reset during the 2nd RUN cycle
        start = 1'b1; data = 16'h0001;
        tick();
        start = 1'b0;
        tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("midrun_reset", {28'd0, ready, busy, valid, parity}, 32'b1000);
        #2 rstn = 1'b1;
        tick();
        check("post_reset_idle", {28'd0, ready, busy, valid, parity}, 32'b1000);
        run_word("post_rst", 16'h0001);

        // WIDTH=4 boundary
        start4 = 1'b1; data4 = 4'hB;
        tick();
        start4 = 1'b0; data4 = 4'h0;
        check("w4_busy", {29'd0, ready4, busy4, valid4}, 32'b010);
        tick();
        check("w4_valid", {29'd0, ready4, busy4, valid4}, 32'b001);
        e = exp_par({12'd0, 4'hB});
        check("w4_parity", {31'd0, parity4}, {31'd0, e});
        ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        check("w4_idle", {28'd0, ready4, busy4, valid4, parity4}, 32'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule
